// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: direction codes, coordinate width,
// default playfield geometry and the head-controller state type.
package snake_pkg;

  localparam int COORD_W = 11;

  localparam int unsigned DEF_STEP  = 20;
  localparam int unsigned DEF_H_MAX = 620;
  localparam int unsigned DEF_V_MAX = 460;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DEAD
  } state_t;

  // Opposite pairs differ only in the LSB: up/down and left/right.
  function automatic logic [1:0] opposite_dir(input logic [1:0] d);
    return d ^ 2'b01;
  endfunction

endpackage

// File: rtl/snake_head_controller_move_tick_gen.sv
// Move-rate counter: counts 0..TICKS-1 while run is high and flags the
// terminal count with a one-cycle tick.
module move_tick_gen #(
  parameter int unsigned TICKS = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] r_count;

  // Counter: clear wins, holds when not running, wraps at the terminal count.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
    end else if (run) begin
      if (r_count == LAST) r_count <= '0;
      else                 r_count <= r_count + 1'b1;
    end
  end

  assign tick = run && (r_count == LAST);

endmodule

// File: rtl/snake_head_controller.sv
// Snake head controller: direction filtering, move timing, wall detection and
// the head-coordinate/step interface feeding the body shift register.
module snake_head_controller
  import snake_pkg::*;
#(
  parameter int unsigned TICKS_PER_MOVE = 25_000_000,
  parameter int unsigned STEP           = DEF_STEP,
  parameter int unsigned H_MIN          = 0,
  parameter int unsigned H_MAX          = DEF_H_MAX,
  parameter int unsigned V_MIN          = 0,
  parameter int unsigned V_MAX          = DEF_V_MAX,
  parameter int unsigned H_START        = 320,
  parameter int unsigned V_START        = 240
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               btn_left,
  input  logic               btn_right,
  input  logic               you_lose_from_collision,
  output logic [COORD_W-1:0] horizontal_head_coord,
  output logic [COORD_W-1:0] vertical_head_coord,
  output logic               step,
  output logic [1:0]         direction,
  output logic               you_lose_from_wall,
  output logic               game_over
);

  localparam logic [11:0] STEP12 = 12'(STEP);
  localparam logic [11:0] X_LO   = 12'(H_MIN + STEP);
  localparam logic [11:0] X_HI   = 12'(H_MAX - STEP);
  localparam logic [11:0] Y_LO   = 12'(V_MIN + STEP);
  localparam logic [11:0] Y_HI   = 12'(V_MAX - STEP);

  state_t             r_state;
  logic [COORD_W-1:0] r_hx, r_hy;
  logic [1:0]         r_direction, r_pending_dir;
  logic               r_step, r_wall, r_game_over;

  logic               w_tick;
  logic               w_req_valid, w_accept, w_legal;
  logic [1:0]         w_req_dir;
  logic [11:0]        w_x12, w_y12;
  logic [COORD_W-1:0] w_next_x, w_next_y;

  move_tick_gen #(.TICKS(TICKS_PER_MOVE)) u_tick (
    .clock (clock),
    .reset (reset),
    .clear (r_state == IDLE),
    .run   (r_state == RUN),
    .tick  (w_tick)
  );

  // Button priority encoder (up > down > left > right) and reversal filter.
  always_comb begin
    w_req_valid = btn_up | btn_down | btn_left | btn_right;
    w_req_dir   = DIR_RIGHT;
    if      (btn_up)   w_req_dir = DIR_UP;
    else if (btn_down) w_req_dir = DIR_DOWN;
    else if (btn_left) w_req_dir = DIR_LEFT;
    w_accept = w_req_valid && (w_req_dir != opposite_dir(r_direction));
  end

  // Next head position and wall legality, checked at 12 bits before stepping.
  always_comb begin
    w_x12    = {1'b0, r_hx};
    w_y12    = {1'b0, r_hy};
    w_next_x = r_hx;
    w_next_y = r_hy;
    w_legal  = 1'b1;
    case (r_pending_dir)
      DIR_UP:    if (w_y12 < Y_LO) w_legal = 1'b0;
                 else w_next_y = COORD_W'(w_y12 - STEP12);
      DIR_DOWN:  if (w_y12 > Y_HI) w_legal = 1'b0;
                 else w_next_y = COORD_W'(w_y12 + STEP12);
      DIR_LEFT:  if (w_x12 < X_LO) w_legal = 1'b0;
                 else w_next_x = COORD_W'(w_x12 - STEP12);
      default:   if (w_x12 > X_HI) w_legal = 1'b0;
                 else w_next_x = COORD_W'(w_x12 + STEP12);
    endcase
  end

  // Game FSM with registered head, direction, step strobe and loss flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hx          <= COORD_W'(H_START);
      r_hy          <= COORD_W'(V_START);
      r_direction   <= DIR_RIGHT;
      r_pending_dir <= DIR_RIGHT;
      r_step        <= 1'b0;
      r_wall        <= 1'b0;
      r_game_over   <= 1'b0;
    end else begin
      r_step <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_valid) begin
            r_direction   <= w_req_dir;
            r_pending_dir <= w_req_dir;
            r_state       <= RUN;
          end
        end
        RUN: begin
          // Collision outranks any move due in the same cycle.
          if (you_lose_from_collision) begin
            r_game_over <= 1'b1;
            r_state     <= DEAD;
          end else begin
            if (w_accept) r_pending_dir <= w_req_dir;
            if (w_tick) begin
              r_direction <= r_pending_dir;
              if (w_legal) begin
                r_hx   <= w_next_x;
                r_hy   <= w_next_y;
                r_step <= 1'b1;
              end else begin
                r_wall      <= 1'b1;
                r_game_over <= 1'b1;
                r_state     <= DEAD;
              end
            end
          end
        end
        DEAD: begin
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign horizontal_head_coord = r_hx;
  assign vertical_head_coord   = r_hy;
  assign step                  = r_step;
  assign direction             = r_direction;
  assign you_lose_from_wall    = r_wall;
  assign game_over             = r_game_over;

endmodule

// File: tb/tb_snake_head_controller.sv
// Directed bench for snake_head_controller with TICKS_PER_MOVE=4, STEP=20.
module tb_snake_head_controller;
  import snake_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        you_lose_from_collision;
  logic [10:0] horizontal_head_coord, vertical_head_coord;
  logic        step;
  logic [1:0]  direction;
  logic        you_lose_from_wall, game_over;

  int checks = 0;
  int errors = 0;
  int n;

  snake_head_controller #(
    .TICKS_PER_MOVE (4),
    .STEP           (20)
  ) dut (
    .clock                   (clock),
    .reset                   (reset),
    .btn_up                  (btn_up),
    .btn_down                (btn_down),
    .btn_left                (btn_left),
    .btn_right               (btn_right),
    .you_lose_from_collision (you_lose_from_collision),
    .horizontal_head_coord   (horizontal_head_coord),
    .vertical_head_coord     (vertical_head_coord),
    .step                    (step),
    .direction               (direction),
    .you_lose_from_wall      (you_lose_from_wall),
    .game_over               (game_over)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Buttons set before the call are held for exactly one sampling edge.
  task automatic wait_step(output int cycles);
    cycles = 0;
    do begin
      @(negedge clock);
      cycles++;
      btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    end while (!step && cycles < 20);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, 32'(horizontal_head_coord), 320);
    chk({tag, "_y"}, 32'(vertical_head_coord), 240);
    chk({tag, "_step"}, 32'(step), 0);
    chk({tag, "_dir"}, 32'(direction), 3);
    chk({tag, "_wall"}, 32'(you_lose_from_wall), 0);
    chk({tag, "_go"}, 32'(game_over), 0);
    chk({tag, "_state"}, 32'(dut.r_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  initial begin
    reset = 1; you_lose_from_collision = 0;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    repeat (2) @(negedge clock);
    reset = 0;
    chk_reset_vals("rst");

    // 1: idle, no buttons
    repeat (50) begin
      @(negedge clock);
      chk("idle_step", 32'(step), 0);
    end
    chk("idle_x", 32'(horizontal_head_coord), 320);
    chk("idle_y", 32'(vertical_head_coord), 240);
    chk("idle_state", 32'(dut.r_state), 32'(IDLE));

    // 2: start right, first move 1+4 edges after the press, then every 4
    btn_right = 1;
    wait_step(n);
    chk("first_lat", n, 5);
    chk("r1_x", 32'(horizontal_head_coord), 340);
    chk("r1_y", 32'(vertical_head_coord), 240);
    chk("r1_dir", 32'(direction), 3);
    for (int i = 2; i <= 3; i++) begin
      wait_step(n);
      chk("r_period", n, 4);
      chk("r_x", 32'(horizontal_head_coord), 32'(320 + 20 * i));
      chk("r_y", 32'(vertical_head_coord), 240);
    end

    // 3: reversal ignored, then turn up
    btn_left = 1;
    wait_step(n);
    chk("rev_period", n, 4);
    chk("rev_x", 32'(horizontal_head_coord), 400);
    chk("rev_dir", 32'(direction), 3);
    btn_up = 1;
    wait_step(n);
    chk("up_period", n, 4);
    chk("up_x", 32'(horizontal_head_coord), 400);
    chk("up_y", 32'(vertical_head_coord), 220);
    chk("up_dir", 32'(direction), 0);

    // button in terminal-count cycle applies to the following move
    repeat (3) @(negedge clock);
    btn_right = 1;
    wait_step(n);
    chk("tc_lat", n, 1);
    chk("tc_x", 32'(horizontal_head_coord), 400);
    chk("tc_y", 32'(vertical_head_coord), 200);
    chk("tc_dir", 32'(direction), 0);
    wait_step(n);
    chk("tc2_period", n, 4);
    chk("tc2_x", 32'(horizontal_head_coord), 420);
    chk("tc2_y", 32'(vertical_head_coord), 200);
    chk("tc2_dir", 32'(direction), 3);

    // 4: run into the right wall
    for (int i = 1; i <= 10; i++) begin
      wait_step(n);
      chk("wr_period", n, 4);
      chk("wr_x", 32'(horizontal_head_coord), 32'(420 + 20 * i));
    end
    repeat (3) begin
      @(negedge clock);
      chk("wall_pre_step", 32'(step), 0);
    end
    chk("wall_pre_go", 32'(game_over), 0);
    @(negedge clock);
    chk("wall_step", 32'(step), 0);
    chk("wall_flag", 32'(you_lose_from_wall), 1);
    chk("wall_go", 32'(game_over), 1);
    chk("wall_x", 32'(horizontal_head_coord), 620);
    chk("wall_state", 32'(dut.r_state), 32'(DEAD));
    repeat (12) begin
      btn_up = 1; btn_left = 1;
      @(negedge clock);
      chk("dead_step", 32'(step), 0);
    end
    btn_up = 0; btn_left = 0;
    chk("dead_x", 32'(horizontal_head_coord), 620);
    chk("dead_y", 32'(vertical_head_coord), 200);
    chk("dead_go", 32'(game_over), 1);
    chk("dead_state", 32'(dut.r_state), 32'(DEAD));

    do_reset();
    chk_reset_vals("rst2");

    // 5: collision coinciding with the terminal count
    btn_right = 1;
    wait_step(n);
    chk("c_lat", n, 5);
    chk("c_x", 32'(horizontal_head_coord), 340);
    repeat (3) @(negedge clock);
    you_lose_from_collision = 1;
    @(negedge clock);
    you_lose_from_collision = 0;
    chk("col_step", 32'(step), 0);
    chk("col_go", 32'(game_over), 1);
    chk("col_wall", 32'(you_lose_from_wall), 0);
    chk("col_x", 32'(horizontal_head_coord), 340);
    chk("col_state", 32'(dut.r_state), 32'(DEAD));
    repeat (8) begin
      @(negedge clock);
      chk("col_dead_step", 32'(step), 0);
    end
    chk("col_dead_x", 32'(horizontal_head_coord), 340);

    do_reset();
    chk_reset_vals("rst3");

    // 6: priority in IDLE, then reset mid-run drops the pending step
    btn_up = 1; btn_left = 1;
    @(negedge clock);
    btn_up = 0; btn_left = 0;
    chk("prio_dir", 32'(direction), 0);
    chk("prio_state", 32'(dut.r_state), 32'(RUN));
    wait_step(n);
    chk("prio_lat", n, 4);
    chk("prio_x", 32'(horizontal_head_coord), 320);
    chk("prio_y", 32'(vertical_head_coord), 220);
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    chk_reset_vals("rst_mid");
    reset = 0;
    repeat (6) begin
      @(negedge clock);
      chk("post_rst_step", 32'(step), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
